bird_physics: RTL

- Datapath stage directly downstream of the bird flap/fall controller. Turns its flap request into a bird vertical position once per video frame, using signed velocity, gravity, a terminal-velocity clamp and screen clamps.
- Each frame update (old y, new y) goes to the VGA bird renderer over a valid/ready handshake.
- Detects ground and ceiling contact for game-over logic.

---
 rtl/bird_physics.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/bird_physics.sv
// Per-frame vertical physics for the bird, with a valid/ready hand-off to the renderer.
// Define BIRD_PHYSICS_OVERRUN_CNT_EN to add the overrun_cnt port (dropped frame ticks).
module bird_physics #(
    parameter int Y_W      = 7,
    parameter int V_W      = 5,
    parameter int Y_START  = 60,
    parameter int Y_MAX    = 112,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = -6,
    parameter int V_TERM   = 4
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           enable,
    input  logic           frame_tick,
    input  logic           flap,
    output logic           upd_valid,
    input  logic           upd_ready,
    output logic [Y_W-1:0] upd_y_old,
    output logic [Y_W-1:0] upd_y_new,
    output logic           upd_ceil,
    output logic [Y_W-1:0] y_out,
    output logic [V_W-1:0] vel_out,
    output logic           ground_hit
`ifdef BIRD_PHYSICS_OVERRUN_CNT_EN
    ,
    output logic [7:0]     overrun_cnt
`endif
);

    localparam logic        [Y_W-1:0] Y_START_V = Y_START[Y_W-1:0];
    localparam logic        [Y_W-1:0] Y_MAX_V   = Y_MAX[Y_W-1:0];
    localparam logic signed [V_W:0]   GRAV_X    = GRAVITY[V_W:0];
    localparam logic signed [V_W:0]   VTERM_X   = V_TERM[V_W:0];
    localparam logic signed [V_W-1:0] FLAP_V    = FLAP_VEL[V_W-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_UPDATE,
        S_PRESENT,
        S_DEAD
    } state_t;

    state_t state, state_next;

    logic                  flap_q;
    logic                  flap_pending;
    logic                  flap_rise;
    logic [Y_W-1:0]        y;
    logic signed [V_W-1:0] vel;
    logic signed [V_W:0]   vel_inc;
    logic signed [V_W-1:0] vel_new;
    logic signed [Y_W+1:0] y_sum;
    logic                  hit_ground;
    logic                  hit_ceil;

    assign flap_rise = flap & ~flap_q;
    assign y_out     = y;
    assign vel_out   = vel;

    // A flap edge landing in the UPDATE cycle itself is folded into that update.
    always_comb begin
        vel_inc = {vel[V_W-1], vel} + GRAV_X;
        vel_new = vel_inc[V_W-1:0];
        if (flap_pending || flap_rise) begin
            vel_new = FLAP_V;
        end else if (vel_inc > VTERM_X) begin
            vel_new = VTERM_X[V_W-1:0];
        end
        y_sum      = $signed({2'b00, y}) + $signed({{(Y_W+2-V_W){vel_new[V_W-1]}}, vel_new});
        hit_ground = y_sum > $signed({2'b00, Y_MAX_V});
        hit_ceil   = y_sum[Y_W+1];
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (enable) state_next = S_WAIT_TICK;
            S_WAIT_TICK: begin
                if (!enable) begin
                    state_next = S_IDLE;
                end else if (frame_tick) begin
                    state_next = S_UPDATE;
                end
            end
            S_UPDATE:    state_next = S_PRESENT;
            S_PRESENT:   if (upd_ready) state_next = ground_hit ? S_DEAD : S_WAIT_TICK;
            S_DEAD:      if (!enable) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= S_IDLE;
            flap_q       <= 1'b0;
            flap_pending <= 1'b0;
            y            <= Y_START_V;
            vel          <= '0;
            upd_valid    <= 1'b0;
            upd_y_old    <= Y_START_V;
            upd_y_new    <= Y_START_V;
            upd_ceil     <= 1'b0;
            ground_hit   <= 1'b0;
        end else begin
            state  <= state_next;
            flap_q <= flap;
            case (state)
                S_IDLE: begin
                    y            <= Y_START_V;
                    vel          <= '0;
                    ground_hit   <= 1'b0;
                    flap_pending <= 1'b0;
                end
                S_WAIT_TICK: if (flap_rise) flap_pending <= 1'b1;
                S_UPDATE: begin
                    flap_pending <= 1'b0;
                    upd_valid    <= 1'b1;
                    upd_y_old    <= y;
                    upd_ceil     <= 1'b0;
                    if (hit_ground) begin
                        y          <= Y_MAX_V;
                        vel        <= '0;
                        upd_y_new  <= Y_MAX_V;
                        ground_hit <= 1'b1;
                    end else if (hit_ceil) begin
                        y         <= '0;
                        vel       <= '0;
                        upd_y_new <= '0;
                        upd_ceil  <= 1'b1;
                    end else begin
                        y         <= y_sum[Y_W-1:0];
                        vel       <= vel_new;
                        upd_y_new <= y_sum[Y_W-1:0];
                    end
                end
                S_PRESENT: begin
                    if (flap_rise) flap_pending <= 1'b1;
                    if (upd_ready) begin
                        upd_valid <= 1'b0;
                        upd_ceil  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BIRD_PHYSICS_OVERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn || state_next == S_IDLE) begin
            overrun_cnt <= '0;
        end else if ((state == S_UPDATE || state == S_PRESENT) && frame_tick
                     && overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

endmodule
